// File: rtl/apb_completer.sv
// APB completer exposing NUM_REGS word registers with byte strobes,
// a fixed number of wait states per transfer, and error signalling.
module apb_completer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [2:0]                     PPROT,
  input  logic                           PNSE,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  output logic                           PREADY,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REG_Q,
  output logic [NUM_REGS-1:0]            REG_WR
);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                              state_q;
  logic [3:0]                          cnt_q;
  logic                                pready_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:0]                 reg_wr_q;

  logic [IW-1:0] idx;
  logic          err, access, commit;
  logic          unused_ok;

  assign idx       = PADDR[2 +: IW];
  assign err       = (PADDR[1:0] != 2'b00) | ((PADDR >> 2) >= ADDR_WIDTH'(NUM_REGS)) | PNSE;
  assign access    = PSEL & PENABLE;
  assign commit    = access & pready_q & PWRITE & ~err;
  assign unused_ok = ^PPROT;

  // PREADY is set on the same edge that enters RESP, so it is a pure flop.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            if (WAIT_CYCLES == 0) begin
              state_q  <= RESP;
              pready_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == 4'd0) begin
            state_q  <= RESP;
            pready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          pready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      regs_q   <= '0;
      reg_wr_q <= '0;
    end else begin
      reg_wr_q <= '0;
      if (commit) begin
        reg_wr_q[idx] <= 1'b1;
        for (int b = 0; b < NB; b++)
          if (PSTRB[b]) regs_q[idx][b*8 +: 8] <= PWDATA[b*8 +: 8];
      end
    end
  end

  // Read data is muxed live so a read sees a write committed on the previous edge.
  assign PREADY  = pready_q;
  assign PRDATA  = (access & pready_q & ~PWRITE & ~err) ? regs_q[idx] : '0;
  assign PSLVERR = access & pready_q & err;
  assign REG_Q   = regs_q;
  assign REG_WR  = reg_wr_q;

endmodule

// File: tb/tb_apb_completer.sv
// Scoreboard bench: three completers (1, 0 and 3 wait states) driven one
// transfer at a time; a negedge monitor checks every output against the queue.
module tb_apb_completer;
  localparam int NR = 8;

  function automatic int wc(int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0]  paddr[3], pwdata[3], prdata[3];
  logic [3:0]   pstrb[3];
  logic         pnse[3], psel[3], penable[3], pwrite[3], pready[3], pslverr[3];
  logic [255:0] regq[3];
  logic [7:0]   regwr[3];
  logic [2:0]   pprot = 3'b000;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR),
                    .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3))) u_dut (
      .PCLK(clk), .PRESET(rst), .PADDR(paddr[g]), .PPROT(pprot), .PNSE(pnse[g]),
      .PSEL(psel[g]), .PENABLE(penable[g]), .PWRITE(pwrite[g]), .PWDATA(pwdata[g]),
      .PSTRB(pstrb[g]), .PREADY(pready[g]), .PRDATA(prdata[g]), .PSLVERR(pslverr[g]),
      .REG_Q(regq[g]), .REG_WR(regwr[g]));
  end

  typedef struct {int k; bit err; bit wr; logic [31:0] rdata; int idx;} exp_t;
  exp_t        sb[$];
  exp_t        e;
  logic [31:0] model[3][NR];
  int          n_cmp = 0, n_bad = 0;
  int          acc[3];
  logic [7:0]  nxt_wr[3];

  task automatic chk(string nm, int k, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  // Monitor: REG_WR pulses, idle-cycle zeros, and PREADY-cycle responses.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("reg_wr", k, regwr[k], nxt_wr[k]);
      nxt_wr[k] = 8'h00;
      if (rst) begin
        acc[k] = 0;
        chk("reset_outs", k, {pready[k], pslverr[k], prdata[k]}, 0);
        chk("reset_regs", k, regq[k], 0);
      end else if (!(psel[k] && penable[k])) begin
        acc[k] = 0;
        chk("idle_outs", k, {pready[k], pslverr[k], prdata[k]}, 0);
      end else begin
        acc[k]++;
        if (!pready[k]) begin
          chk("wait_outs", k, {pslverr[k], prdata[k]}, 0);
        end else if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_pready dut%0d: got pready with no transfer expected", k);
        end else begin
          e = sb.pop_front();
          chk("latency", k, acc[k], wc(k) + 1);
          chk("pslverr", k, pslverr[k], e.err);
          chk("prdata", k, prdata[k], e.rdata);
          if (e.wr && !e.err) nxt_wr[k] = 8'(1 << e.idx);
          acc[k] = 0;
        end
      end
    end
  end

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      psel[k] = 0; penable[k] = 0; pwrite[k] = 0; pnse[k] = 0;
      paddr[k] = 0; pwdata[k] = 0; pstrb[k] = 0;
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NR; i++) model[k][i] = 32'h0;
  endtask

  task automatic gap();
    @(posedge clk); #1;
    idle_all();
  endtask

  // ab: access cycle in which the transfer is abandoned (0 = none);
  // ab_rst selects abandoning by reset instead of dropping PSEL.
  task automatic xfer(int k, logic [31:0] a, bit w, logic [31:0] d, logic [3:0] s,
                      bit nse, int ab, bit ab_rst);
    bit   err, done;
    int   idx;
    exp_t x;
    err  = (a[1:0] != 2'b00) || ((a >> 2) >= NR) || nse;
    idx  = int'(a[4:2]);
    done = 0;
    @(posedge clk); #1;
    idle_all();
    psel[k] = 1; penable[k] = 0; paddr[k] = a; pwrite[k] = w;
    pwdata[k] = d; pstrb[k] = s; pnse[k] = nse;
    if (ab == 0) begin
      x.k = k; x.err = err; x.wr = w; x.idx = idx;
      x.rdata = (!w && !err) ? model[k][idx] : 32'h0;
      if (w && !err)
        for (int b = 0; b < 4; b++)
          if (s[b]) model[k][idx][8*b +: 8] = d[8*b +: 8];
      sb.push_back(x);
    end
    @(posedge clk); #1;
    penable[k] = 1;
    for (int c = 1; c <= 40; c++) begin
      if (c == ab) begin
        if (ab_rst) begin
          rst = 1;
          repeat (2) @(posedge clk);
          #1;
          idle_all();
          clear_model();
          rst = 0;
        end else begin
          psel[k] = 0; penable[k] = 0;
        end
        return;
      end
      @(negedge clk);
      if (pready[k]) begin
        done = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout dut%0d: no PREADY within 40 access cycles, addr %0h", k, a);
    end
  endtask

  logic [31:0] ra;
  int          r, ab;

  initial begin
    for (int k = 0; k < 3; k++) begin acc[k] = 0; nxt_wr[k] = 8'h00; end
    rst = 1;
    idle_all();
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // 1 wait state: write then read back reg 1
    xfer(0, 32'h04, 1, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    xfer(0, 32'h04, 0, 32'h0, 4'h0, 0, 0, 0);
    // strobed partial write to reg 2
    xfer(0, 32'h08, 1, 32'h11223344, 4'hF, 0, 0, 0);
    xfer(0, 32'h08, 1, 32'hAABBCCDD, 4'h5, 0, 0, 0);
    xfer(0, 32'h08, 0, 32'h0, 4'h0, 0, 0, 0);
    chk("strobe_merge", 0, regq[0][95:64], 32'h11BB33DD);
    // out-of-range read and misaligned write
    xfer(0, 32'h20, 0, 32'h0, 4'h0, 0, 0, 0);
    xfer(0, 32'h06, 1, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    xfer(0, 32'h04, 1, 32'h12345678, 4'hF, 1, 0, 0);
    gap();
    // zero wait states: back-to-back writes to regs 0..2
    xfer(1, 32'h00, 1, 32'hA0A0A0A0, 4'hF, 0, 0, 0);
    xfer(1, 32'h04, 1, 32'hB1B1B1B1, 4'hF, 0, 0, 0);
    xfer(1, 32'h08, 1, 32'hC2C2C2C2, 4'hF, 0, 0, 0);
    xfer(1, 32'h04, 0, 32'h0, 4'h0, 0, 0, 0);
    gap();
    // 3 wait states: abort by dropping PSEL, then a normal transfer
    xfer(2, 32'h0C, 1, 32'h55AA55AA, 4'hF, 0, 2, 0);
    xfer(2, 32'h0C, 0, 32'h0, 4'h0, 0, 0, 0);
    // reset in the middle of a write to reg 0
    xfer(2, 32'h00, 1, 32'h87654321, 4'hF, 0, 0, 0);
    xfer(2, 32'h00, 1, 32'hCAFEF00D, 4'hF, 0, 2, 1);
    xfer(2, 32'h00, 0, 32'h0, 4'h0, 0, 0, 0);
    gap();

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 40; n++) begin
        r = $urandom_range(0, 9);
        if (r <= 6)      ra = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
        else if (r == 7) ra = 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
        else if (r == 8) ra = 32'(32'h20 + 4 * $urandom_range(0, 7));
        else             ra = $urandom;
        ab = (wc(k) > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, wc(k)) : 0;
        xfer(k, ra, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
             ($urandom_range(0, 7) == 0), ab, 0);
        if ($urandom_range(0, 3) == 0) gap();
      end
      gap();
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NR; i++)
        chk("reg_q_final", k, regq[k][i*32 +: 32], model[k][i]);
    chk("sb_drained", 0, sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
